// File: rtl/mul_sequencer.sv
// Sequencer between the execute stage and the shift-add multiplier: launches a multiply, stalls the pipe, returns the product.
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand skips the multiplier and returns 0 straight away.
module mul_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mul_req,
  input  logic        flush,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        timeout_err,
  output logic        mul_st,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_done,
  input  logic        mul_idle,
  input  logic [31:0] mul_product,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic             err_q, err_d;
  logic             zero_op;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (op_a == 16'd0) || (op_b == 16'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = mul_req;
        if (flush) begin
          state_d = S_IDLE;
        end else if (mul_req && zero_op) begin
          result_d = '0;
          state_d  = S_DONE;
        end else if (mul_req && mul_idle) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        stall   = 1'b1;
        cnt_d   = '0;
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // A done arriving on the last allowed cycle still counts as success.
          if (mul_done) begin
            result_d = mul_product;
            state_d  = S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Wait for the aborted multiply to finish before accepting new work.
        stall = mul_req;
        if (mul_idle) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result       = result_q;
  assign result_valid = (state_q == S_DONE) && !flush;
  assign timeout_err  = err_q;
  assign mul_st       = (state_q == S_LAUNCH);
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: behavioural multiplier model plus a transaction-level reference for latency, product and error flag.
module tb_mul_sequencer;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic        clock;
  logic        reset;
  logic        mul_req;
  logic        flush;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        timeout_err;
  logic        mul_st;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_done;
  logic        mul_idle;
  logic [31:0] mul_product;
  logic [2:0]  dbg_state;

  mul_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .mul_req     (mul_req),
    .flush       (flush),
    .op_a        (op_a),
    .op_b        (op_b),
    .stall       (stall),
    .result      (result),
    .result_valid(result_valid),
    .timeout_err (timeout_err),
    .mul_st      (mul_st),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_idle    (mul_idle),
    .mul_product (mul_product),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- multiplier model ----------------
  int          mdl_lat;
  int          mdl_rem;
  logic [31:0] mdl_prod;
  bit          force_busy;

  assign mul_done    = (mdl_rem == 1);
  assign mul_idle    = (mdl_rem == 0) && !force_busy;
  assign mul_product = (mdl_rem == 1) ? mdl_prod : ~mdl_prod;

  // ---------------- scoreboard state ----------------
  int          n_checks;
  int          n_pass;
  logic        exp_err;
  logic [31:0] last_res;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One clock: the model sees mul_st as it was during the cycle just ending.
  task automatic step();
    bit          st_seen;
    logic [31:0] ma;
    logic [31:0] mb;
    st_seen = mul_st;
    ma = {16'd0, mul_a};
    mb = {16'd0, mul_b};
    @(posedge clock);
    #1;
    if (st_seen) begin
      mdl_rem  = mdl_lat;
      mdl_prod = ma * mb;
    end else if (mdl_rem > 0) begin
      mdl_rem--;
    end
  endtask

  // ---------------- driver + reference model ----------------
  // pre: cycles before the sequencer can launch (busy multiplier or drain exit).
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input int lat,
                        input int pre, input bit forced, input string tag);
    int          exp_cyc;
    int          exp_st;
    int          got_cyc;
    int          st_cyc;
    int          st_cnt;
    int          n_valid;
    bit          stall_bad;
    bit          byp;
    logic [31:0] aa;
    logic [31:0] bb;
    logic [31:0] exp_res;
    logic [31:0] got_res;
    logic        got_err;
    aa = {16'd0, a};
    bb = {16'd0, b};
    byp = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
    byp = (a == 16'd0) || (b == 16'd0);
`endif
    if (byp) begin
      exp_cyc = 1;
      exp_st  = 0;
      exp_res = 32'd0;
    end else if (lat > TIMEOUT) begin
      exp_cyc = pre + TIMEOUT + 2;
      exp_st  = 1;
      exp_res = 32'd0;
      exp_err = 1'b1;
    end else begin
      exp_cyc = pre + lat + 2;
      exp_st  = 1;
      exp_res = aa * bb;
    end
    exp_q.push_back(exp_res);

    mdl_lat    = lat;
    force_busy = forced;
    op_a       = a;
    op_b       = b;
    mul_req    = 1'b1;
    got_cyc    = -1;
    st_cyc     = -1;
    st_cnt     = 0;
    n_valid    = 0;
    stall_bad  = 1'b0;
    got_res    = 32'hxxxxxxxx;
    got_err    = 1'bx;
    for (int k = 0; k <= exp_cyc; k++) begin
      if (k == pre) force_busy = 1'b0;
      #1;
      if (result_valid) begin
        n_valid++;
        got_cyc = k;
      end
      if (mul_st) begin
        st_cnt++;
        st_cyc = k;
      end
      if (stall !== (k < exp_cyc)) stall_bad = 1'b1;
      if (k == exp_cyc) begin
        got_res = result;
        got_err = timeout_err;
        mul_req = 1'b0;
      end
      step();
    end
    if (result_valid) n_valid++;

    chk({tag, "_valid_cycle"}, got_cyc, exp_cyc);
    chk({tag, "_valid_pulses"}, n_valid, 1);
    chk({tag, "_st_count"}, st_cnt, exp_st);
    if (exp_st == 1) chk({tag, "_st_cycle"}, st_cyc, pre + 1);
    chk({tag, "_result"}, got_res, exp_q.pop_front());
    chk({tag, "_timeout_err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, "_stall"}, {31'd0, stall_bad}, 32'd0);
    last_res = exp_res;
    mdl_rem  = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks   = 0;
    n_pass     = 0;
    exp_err    = 1'b0;
    last_res   = 32'd0;
    reset      = 1'b0;
    mul_req    = 1'b0;
    flush      = 1'b0;
    op_a       = 16'd0;
    op_b       = 16'd0;
    mdl_lat    = 1;
    mdl_rem    = 0;
    mdl_prod   = 32'd0;
    force_busy = 1'b0;

    #12;
    chk("rst_result", result, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_mul_st", {31'd0, mul_st}, 32'd0);
    chk("rst_mul_ab", {mul_a, mul_b}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    do_mul(16'h0003, 16'h0005, 4, 0, 1'b0, "basic");
    do_mul(16'hFFFF, 16'hFFFF, 3, 0, 1'b0, "max_ops");
    do_mul(16'h1234, 16'h00AB, 2, 3, 1'b1, "busy");
    do_mul(16'h0101, 16'h0202, TIMEOUT, 0, 1'b0, "done_at_limit");
    do_mul(16'h0000, 16'h1234, 2, 0, 1'b0, "zero_op");
    do_mul(16'h0007, 16'h0009, TIMEOUT + 1, 0, 1'b0, "timeout");
    do_mul(16'h0010, 16'h0010, 1, 0, 1'b0, "after_timeout");

    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      int          rlat;
      int          rpre;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rlat = $urandom_range(1, TIMEOUT + 3);
      rpre = $urandom_range(0, 2);
      do_mul(ra, rb, rlat, rpre, rpre > 0, $sformatf("rnd%0d", i));
    end

    // Flush two cycles after the launch pulse while the multiplier stays busy.
    do_mul(16'h00C3, 16'h0021, 2, 0, 1'b0, "pre_flush");
    mdl_lat = 1000;
    op_a    = 16'h0F0F;
    op_b    = 16'h0033;
    mul_req = 1'b1;
    step();
    step();
    step();
    flush = 1'b1;
    #1;
    chk("flush_cycle_valid", {31'd0, result_valid}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("drain_stall_req", {31'd0, stall}, 32'd1);
    chk("drain_valid", {31'd0, result_valid}, 32'd0);
    mul_req = 1'b0;
    #1;
    chk("drain_stall_noreq", {31'd0, stall}, 32'd0);
    step();
    step();
    chk("drain_result_kept", result, last_res);
    chk("drain_valid_late", {31'd0, result_valid}, 32'd0);
    chk("drain_no_st", {31'd0, mul_st}, 32'd0);
    mdl_rem = 0;
    do_mul(16'h0ABC, 16'h0002, 3, 1, 1'b0, "after_drain");

    // Asynchronous reset in the middle of a wait.
    mdl_lat = 1000;
    op_a    = 16'h0055;
    op_b    = 16'h0066;
    mul_req = 1'b1;
    step();
    step();
    step();
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    #2;
    mul_req = 1'b0;
    reset   = 1'b0;
    #1;
    chk("areset_mul_st", {31'd0, mul_st}, 32'd0);
    chk("areset_stall", {31'd0, stall}, 32'd0);
    chk("areset_result", result, 32'd0);
    chk("areset_valid", {31'd0, result_valid}, 32'd0);
    chk("areset_err", {31'd0, timeout_err}, 32'd0);
    chk("areset_mul_ab", {mul_a, mul_b}, 32'd0);
    @(negedge clock);
    reset   = 1'b1;
    mdl_rem = 0;
    exp_err = 1'b0;
    step();
    do_mul(16'h0100, 16'h0100, 5, 0, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
